// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fuladder.sv
// One-bit full-adder cell (fuladder).
// Ports: a, b, c  - addend bits and carry-in
//        sum      - a ^ b ^ c
//        carry    - majority(a, b, c)
module fuladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in one
// bit per clock, LSB first, through a single full-adder cell.
// Ports: clk, rst (sync, active-high)
//        start, a, b, cin  - request and operands, sampled on the accept edge
//        busy              - high while the addition runs
//        done              - one-cycle pulse when sum/cout are fresh
//        sum, cout         - registered result, held between runs
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_fa_sum;
  logic             w_fa_carry;

  fuladder u_fa (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c     (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // Result shift register input: new sum bit enters at the MSB so that after
  // WIDTH shifts the LSB-first bits land in their natural positions.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_fa_sum;
  end

  // Next-state logic; start is honoured only from IDLE or DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = (r_cnt == CW'(WIDTH - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end else begin
          w_next   = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE: begin
        if (start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end else begin
          w_next   = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Datapath: operand load on accept, one bit per RUN edge, result capture on
  // the final RUN edge. The counter stops at WIDTH and is cleared on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_res   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= {CW{1'b0}};
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_fa_carry;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         cout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference model for the WIDTH=8 instance: an operation is an event at an
  // accept edge; busy spans the W edges after it, done marks edge W, and the
  // visible result is the last completed a+b+cin.
  bit           m_act = 1'b0;
  int           m_el  = 0;
  logic [W:0]   m_pend;
  logic [W:0]   m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      m_el  = 0;
      m_res = '0;
    end else if (start && !(m_act && m_el < W)) begin
      m_act  = 1'b1;
      m_el   = 0;
      m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end else if (m_act) begin
      m_el++;
      if (m_el == W) m_res = m_pend;
      if (m_el > W)  m_act = 1'b0;
    end
    #1;
    chk("model_busy", {63'd0, busy}, {63'd0, (m_act && m_el < W)});
    chk("model_done", {63'd0, done}, {63'd0, (m_act && m_el == W)});
    chk("model_result", {55'd0, cout, sum}, {55'd0, m_res});
  end

  // Run one operation with a single-cycle start; operands are scrambled after
  // the accept edge to show they are not resampled.
  task automatic run_op(input string nm, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int n;
    int bc;
    start = 1'b1; a = va; b = vb; cin = vc;
    tick;
    start = 1'b0; a = ~va; b = va ^ vb; cin = ~vc;
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      tick;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd8);
    chk({nm, "_sum"}, {56'd0, sum}, {56'd0, es});
    chk({nm, "_cout"}, {63'd0, cout}, {63'd0, ec});
    tick;
    chk({nm, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int dcount;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    tick; tick;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_sum", {56'd0, sum}, 64'd0);
    chk("reset_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;
    tick;

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Start pulsed during RUN must be ignored.
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick;
    start = 1'b0;
    tick; tick;
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick;
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin tick; n++; end
    chk("ignore_latency", 64'(n), 64'd8);
    chk("ignore_sum", {56'd0, sum}, 64'h46);
    chk("ignore_cout", {63'd0, cout}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin tick; if (done === 1'b1) dcount++; end
    chk("ignore_single_done", 64'(dcount), 64'd0);

    // Reset mid-run aborts with no done and clears the held result.
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {56'd0, sum}, 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin tick; if (done === 1'b1) dcount++; end
    chk("abort_no_done", 64'(dcount), 64'd0);

    // Back-to-back with start held high.
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    tick;
    a = 8'h03; b = 8'h04;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick; n++; end
    chk("b2b_first_latency", 64'(n), 64'd8);
    chk("b2b_first_sum", {56'd0, sum}, 64'h03);
    tick;
    chk("b2b_rerun_busy", {63'd0, busy}, 64'd1);
    a = 8'h55; b = 8'h66;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick; n++; end
    start = 1'b0;
    chk("b2b_period", 64'(n + 1), 64'd9);
    chk("b2b_second_sum", {56'd0, sum}, 64'h07);
    chk("b2b_second_cout", {63'd0, cout}, 64'd0);
    tick; tick;

    // WIDTH=1: every input combination, done two edges after accept.
    for (int i = 0; i < 8; i++) begin
      int exp1;
      exp1 = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      start1 = 1'b1; a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); cin1 = 1'(i & 1);
      tick;
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      chk($sformatf("w1_busy_%0d", i), {62'd0, busy1, done1}, 64'd2);
      tick;
      chk($sformatf("w1_done_%0d", i), {62'd0, busy1, done1}, 64'd1);
      chk($sformatf("w1_result_%0d", i), {62'd0, cout1, sum1}, 64'(exp1));
      tick;
      chk($sformatf("w1_idle_%0d", i), {62'd0, busy1, done1}, 64'd0);
      chk($sformatf("w1_hold_%0d", i), {62'd0, cout1, sum1}, 64'(exp1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range SHALL be 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port cout, output, 1 bit: the registered carry-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Start SHALL be accepted on any edge where start=1 and the state is IDLE or DONE.
REQ-014 On the accept edge the block SHALL load a and b into shift registers, load cin into the carry flop, clear the bit counter and enter RUN.
REQ-015 In RUN, each edge SHALL add one bit pair, LSB first, through a single one-bit full-adder cell; the cell's sum bit SHALL shift into the result shift register MSB and its carry SHALL update the carry flop.
REQ-016 After exactly WIDTH RUN edges, the FSM SHALL enter DONE, copy the shift register to sum and the carry flop to cout on that same edge, and raise done.
REQ-017 DONE SHALL last one cycle; the next edge SHALL go to IDLE, or to RUN if start=1 (back-to-back operation, no idle cycle).
REQ-018 Latency: with the accept at edge 0, done SHALL be high for the cycle after edge WIDTH; throughput SHALL be one result per WIDTH+1 cycles.
REQ-019 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-020 Start while in RUN SHALL be ignored with no side effects; the operands in flight SHALL be unaffected.
REQ-021 sum and cout SHALL change only on the RUN-to-DONE edge and SHALL hold the previous result throughout IDLE and RUN.
REQ-022 The result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide, SHALL not wrap during a run, and WIDTH=1 SHALL complete in one RUN cycle.
REQ-024 Changes on a, b or cin outside the accept edge SHALL have no effect.

Reset
REQ-025 When rst=1 at an edge, the block SHALL go to IDLE and set busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0 and shift registers=0.
REQ-026 rst SHALL take priority over start; a reset mid-RUN SHALL abort the addition with no done pulse and no update to sum or cout.
REQ-027 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-028 The FSM state encoding (IDLE/RUN/DONE typedef) SHALL live in the shared package serial_add_pkg, alongside the default WIDTH constant.
REQ-029 The one-bit add SHALL be a single instance of the team's existing full-adder cell fuladder (inputs a, b, c; outputs sum, carry); no other sub-module SHALL be used.
REQ-030 The shift registers, carry flop, counter, FSM and result registers SHALL all reside in serial_add_ctrl.

Verification
REQ-031 The bench SHALL cover, at WIDTH=8: reset, then a=0x00, b=0x00, cin=0 with start for one cycle -> busy for 8 cycles, done for 1 cycle, sum=0x00, cout=0.
REQ-032 The bench SHALL cover, at WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-033 The bench SHALL cover, at WIDTH=8: a=0x12, b=0x34 started, then start pulsed with a=0xFF, b=0xFF at RUN cycle 3 -> ignored, sum=0x46, cout=0, exactly one done pulse.
REQ-034 The bench SHALL cover, at WIDTH=8: a=0x80, b=0x80 started, then rst raised at RUN cycle 4 -> next cycle IDLE, busy=0, done never pulses, sum=0x00, cout=0 (reset values).
REQ-035 The bench SHALL cover, at WIDTH=8: start held high continuously with a=0x01, b=0x02, then a=0x03, b=0x04 -> done at cycle 9 with sum=0x03, then at cycle 18 with sum=0x07.
REQ-036 The bench SHALL cover, at WIDTH=1: all 8 {a,b,cin} combinations -> {cout,sum} matches a+b+cin each time, done at cycle 2 after each accept.
